alu_cmd_sequencer: RTL



---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts one ALU command at a time from a host and
// writes it as a packed {op, b, a} word into the downstream input FIFO.
// The FIFO has no backpressure, so FIFO occupancy is tracked here as credits.
// Optional feature macro: ALU_SEQ_DIV0_DROP_EN drops divide-by-zero commands
// instead of issuing them, and counts them in drop_cnt.
module alu_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [1:0]               host_op,
  input  logic [3:0]               host_a,
  input  logic [3:0]               host_b,
  output logic [9:0]               data,
  output logic                     valid,
  input  logic                     consume,
  output logic [$clog2(DEPTH):0]   credits,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     credit_err
);

  localparam int CRED_W = $clog2(DEPTH) + 1;
  localparam logic [CRED_W-1:0] FULL = CRED_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [9:0]        cmd_word;
  logic [9:0]        last_data;
  logic              host_ready_q;
  logic [CRED_W-1:0] credits_q;
  logic              accept;
  logic              issue;
  logic              consume_eff;
  logic              div0_hit;

  // A consume while the FIFO is already empty is bogus and must not add a credit
  assign consume_eff = consume && (credits_q != FULL);

`ifdef ALU_SEQ_DIV0_DROP_EN
  assign div0_hit = (cmd_word[9:8] == 2'b11) && (cmd_word[7:4] == 4'd0);
`else
  assign div0_hit = 1'b0;
`endif

  // Next-state logic; ISSUE may use a same-cycle consume, STALL waits for a registered credit
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (host_valid && host_ready_q) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (div0_hit) begin
          next_state = IDLE;
        end else if ((credits_q != '0) || consume_eff) begin
          issue      = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = STALL;
        end
      end
      STALL: begin
        if (credits_q != '0) begin
          issue      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // host_ready is registered so it only goes high once the FSM is back in IDLE
  always_ff @(posedge clk) begin
    if (reset) host_ready_q <= 1'b0;
    else       host_ready_q <= (next_state == IDLE);
  end

  // Command register captures the host fields at acceptance; the host holds nothing afterwards
  always_ff @(posedge clk) begin
    if (reset)       cmd_word <= '0;
    else if (accept) cmd_word <= {host_op, host_b, host_a};
  end

  // Remembers the last issued word so data stays stable between strobes
  always_ff @(posedge clk) begin
    if (reset)      last_data <= '0;
    else if (issue) last_data <= cmd_word;
  end

  // Credit counter: issue takes a slot, consume returns one, both together cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= FULL;
    end else begin
      case ({issue, consume_eff})
        2'b10:   credits_q <= credits_q - CRED_W'(1);
        2'b01:   credits_q <= credits_q + CRED_W'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Sticky flag for consume pulses that arrive with the FIFO already empty
  always_ff @(posedge clk) begin
    if (reset)                          credit_err <= 1'b0;
    else if (consume && credits_q == FULL) credit_err <= 1'b1;
  end

  // Wrapping count of words written into the FIFO
  always_ff @(posedge clk) begin
    if (reset)      issued_cnt <= '0;
    else if (issue) issued_cnt <= issued_cnt + CNT_W'(1);
  end

`ifdef ALU_SEQ_DIV0_DROP_EN
  // Wrapping count of divide-by-zero commands discarded in ISSUE
  always_ff @(posedge clk) begin
    if (reset)                            drop_cnt <= '0;
    else if (state == ISSUE && div0_hit)  drop_cnt <= drop_cnt + CNT_W'(1);
  end
`else
  assign drop_cnt = '0;
`endif

  assign host_ready = host_ready_q;
  assign valid      = issue;
  assign data       = issue ? cmd_word : last_data;
  assign credits    = credits_q;

endmodule
